temp_meas_ctrl: RTL and testbench
=================================

TEMP_MEAS_CTRL -- requirements
Module: temp_meas_ctrl

Interface
REQ-001 Parameter SIZE, default 32: width of counts and Q15 fixed-point temperature words.
REQ-002 Parameter AVG_LOG, default 2: a burst averages 2^AVG_LOG conversions.
REQ-003 Parameter TIMEOUT, default 64: maximum cycles spent waiting for one conversion result.
REQ-004 One clock; reset is asynchronous and active-high. Ports clk and rst.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 meas_req  input  1  one-cycle request to start a burst.
REQ-008 cnt_valid  input  1  one-cycle strobe: new n_ref_in/n_echo_in pair is present.
REQ-009 n_ref_in, n_echo_in  input  SIZE each  reference and echo period counts.
REQ-010 calc_strt  output  1  registered one-cycle start pulse to the temperature datapath.
REQ-011 calc_n_ref, calc_n_echo  output  SIZE each  latched operands, held stable from calc_strt until the result is accepted.
REQ-012 calc_temp  input  SIZE  datapath result, Q15 sign-magnitude.
REQ-013 calc_rdy  input  1  datapath complete flag, level or pulse.
REQ-014 temp_avg  output  SIZE  averaged temperature, Q15.
REQ-015 avg_valid  output  1  one-cycle pulse: temp_avg has been updated.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 err_zero, err_timeout, err_range  output  1 each  sticky error flags.
REQ-018 err_clr  input  1  clears all three sticky error flags.

Function
REQ-019 The FSM has the states IDLE, WAIT_CNT, START, WAIT_CALC, ACCUM and DONE, one-hot or binary.
REQ-020 IDLE: on meas_req, clear the accumulator and the sample counter, then go to WAIT_CNT; meas_req in any other state is ignored.
REQ-021 WAIT_CNT: on cnt_valid with n_echo_in != 0, latch both operands and go to START.
REQ-022 WAIT_CNT: on cnt_valid with n_echo_in == 0, set err_zero, discard the pair and stay in WAIT_CNT.
REQ-023 START: calc_strt is high for exactly this one cycle, the timer is cleared, and the FSM goes to WAIT_CALC; calc_strt therefore rises on the cycle after the accepted cnt_valid.
REQ-024 WAIT_CALC: calc_rdy is sampled only in this state and is ignored elsewhere.
REQ-025 WAIT_CALC, calc_rdy=1 and calc_temp[SIZE-1]=0: add calc_temp to the accumulator and go to ACCUM.
REQ-026 WAIT_CALC, calc_rdy=1 and calc_temp[SIZE-1]=1: set err_range, abort the burst, go to IDLE, and do not pulse avg_valid.
REQ-027 WAIT_CALC, no calc_rdy: the timer increments each cycle; on the TIMEOUT-th cycle set err_timeout, abort to IDLE, and do not pulse avg_valid.
REQ-028 The accumulator is SIZE+AVG_LOG bits, unsigned, and never wraps for valid inputs.
REQ-029 ACCUM: increment the sample counter; after the 2^AVG_LOG-th sample go to DONE, otherwise go to WAIT_CNT.
REQ-030 DONE: temp_avg <= accumulator >> AVG_LOG (truncated); avg_valid pulses in this cycle; the FSM returns to IDLE.
REQ-031 temp_avg holds its value between bursts and is not changed by aborted bursts.
REQ-032 err_clr has priority over an error being set in the same cycle; the flags do not affect FSM flow.

Reset
REQ-033 rst forces IDLE and clears the accumulator, sample counter and timer, including mid-burst.
REQ-034 rst clears calc_strt, calc_n_ref, calc_n_echo, temp_avg, avg_valid, busy, err_zero, err_timeout and err_range to 0.
REQ-035 After rst is released, the first meas_req is accepted on the first clock edge.

Verification
REQ-036 Averaging (AVG_LOG=2): calc_temp sequence 819200, 819200, 852000, 852000 -> single avg_valid pulse, temp_avg=835600, busy=0 on the following cycle.
REQ-037 Handshake: cnt_valid at cycle k with n_ref=1000, n_echo=900 -> calc_strt high only at cycle k+1; calc_n_ref=1000 and calc_n_echo=900 held through calc_rdy.
REQ-038 Timeout (TIMEOUT=64): calc_rdy held low -> err_timeout=1 after 64 cycles in WAIT_CALC, busy=0, no avg_valid, temp_avg unchanged.
REQ-039 Zero echo: cnt_valid with n_echo_in=0 -> err_zero=1, no calc_strt; the next pair with n_echo=500 proceeds normally; err_clr -> err_zero=0.
REQ-040 Negative result: calc_temp=0x8000_1000 -> err_range=1, abort to IDLE, no avg_valid.
REQ-041 Reset mid-burst and busy request: rst asserted in WAIT_CALC after 2 samples -> all outputs 0 and a fresh burst yields the correct average; meas_req while busy=1 has no effect.

Source files
------------

// File: rtl/temp_meas_ctrl.sv
// Burst temperature measurement controller: hands count pairs to an external
// temperature datapath, averages 2^AVG_LOG results and keeps sticky error flags.
module temp_meas_ctrl #(
  parameter int SIZE    = 32,
  parameter int AVG_LOG = 2,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            meas_req,
  input  logic            cnt_valid,
  input  logic [SIZE-1:0] n_ref_in,
  input  logic [SIZE-1:0] n_echo_in,
  output logic            calc_strt,
  output logic [SIZE-1:0] calc_n_ref,
  output logic [SIZE-1:0] calc_n_echo,
  input  logic [SIZE-1:0] calc_temp,
  input  logic            calc_rdy,
  output logic [SIZE-1:0] temp_avg,
  output logic            avg_valid,
  output logic            busy,
  output logic            err_zero,
  output logic            err_timeout,
  output logic            err_range,
  input  logic            err_clr,
  output logic [2:0]      state_dbg
);

  // Handshakes: cnt_valid, calc_rdy and meas_req are single-sided strobes with
  // no back-pressure; each is only acted on in the state that consumes it
  // (IDLE for meas_req, WAIT_CNT for cnt_valid, WAIT_CALC for calc_rdy).

  localparam int ACC_W = SIZE + AVG_LOG;
  localparam int CNT_W = AVG_LOG + 1;
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] N_SAMP   = CNT_W'(1 << AVG_LOG);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_CNT  = 3'd1,
    START     = 3'd2,
    WAIT_CALC = 3'd3,
    ACCUM     = 3'd4,
    DONE      = 3'd5
  } state_t;

  state_t             state, state_nxt;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   smp_cnt;
  logic [TMR_W-1:0]   timer;

  logic acc_clr, op_load, zero_hit, tmr_clr, tmr_inc;
  logic add_en, range_hit, timeout_hit, cnt_inc, avg_load;

  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    acc_clr     = 1'b0;
    op_load     = 1'b0;
    zero_hit    = 1'b0;
    tmr_clr     = 1'b0;
    tmr_inc     = 1'b0;
    add_en      = 1'b0;
    range_hit   = 1'b0;
    timeout_hit = 1'b0;
    cnt_inc     = 1'b0;
    avg_load    = 1'b0;
    case (state)
      IDLE: begin
        if (meas_req) begin
          acc_clr   = 1'b1;
          state_nxt = WAIT_CNT;
        end
      end
      WAIT_CNT: begin
        if (cnt_valid) begin
          if (n_echo_in != '0) begin
            op_load   = 1'b1;
            state_nxt = START;
          end else begin
            zero_hit  = 1'b1;
          end
        end
      end
      START: begin
        tmr_clr   = 1'b1;
        state_nxt = WAIT_CALC;
      end
      WAIT_CALC: begin
        if (calc_rdy) begin
          // A set sign bit means a negative temperature, which the unsigned
          // accumulator cannot represent, so the whole burst is dropped.
          if (calc_temp[SIZE-1]) begin
            range_hit = 1'b1;
            state_nxt = IDLE;
          end else begin
            add_en    = 1'b1;
            state_nxt = ACCUM;
          end
        end else if (timer == TMR_LAST) begin
          timeout_hit = 1'b1;
          state_nxt   = IDLE;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      ACCUM: begin
        cnt_inc = 1'b1;
        if (smp_cnt + CNT_W'(1) == N_SAMP) begin
          avg_load  = 1'b1;
          state_nxt = DONE;
        end else begin
          state_nxt = WAIT_CNT;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath registers; temp_avg loads on entry to DONE so it is valid
  // in the same cycle that avg_valid is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc         <= '0;
      smp_cnt     <= '0;
      timer       <= '0;
      calc_strt   <= 1'b0;
      calc_n_ref  <= '0;
      calc_n_echo <= '0;
      temp_avg    <= '0;
      avg_valid   <= 1'b0;
    end else begin
      calc_strt <= (state_nxt == START);
      avg_valid <= (state_nxt == DONE);
      if (acc_clr) begin
        acc     <= '0;
        smp_cnt <= '0;
      end else begin
        if (add_en)  acc     <= acc + ACC_W'(calc_temp);
        if (cnt_inc) smp_cnt <= smp_cnt + CNT_W'(1);
      end
      if (tmr_clr)      timer <= '0;
      else if (tmr_inc) timer <= timer + TMR_W'(1);
      if (op_load) begin
        calc_n_ref  <= n_ref_in;
        calc_n_echo <= n_echo_in;
      end
      if (avg_load) temp_avg <= SIZE'(acc >> AVG_LOG);
    end
  end

  // Sticky error flags; a clear request wins over a same-cycle set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_zero    <= 1'b0;
      err_timeout <= 1'b0;
      err_range   <= 1'b0;
    end else if (err_clr) begin
      err_zero    <= 1'b0;
      err_timeout <= 1'b0;
      err_range   <= 1'b0;
    end else begin
      if (zero_hit)    err_zero    <= 1'b1;
      if (timeout_hit) err_timeout <= 1'b1;
      if (range_hit)   err_range   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_temp_meas_ctrl.sv
// Bench for temp_meas_ctrl: acts as count source and temperature datapath,
// predicts averages and error flags from burst-level arithmetic.
module tb_temp_meas_ctrl;

  localparam int SIZE    = 32;
  localparam int AVG_LOG = 2;
  localparam int TIMEOUT = 64;
  localparam int NS      = 1 << AVG_LOG;

  // clock / reset / DUT
  logic            clk, rst;
  logic            meas_req, cnt_valid, calc_rdy, err_clr;
  logic [SIZE-1:0] n_ref_in, n_echo_in, calc_temp;
  logic            calc_strt, avg_valid, busy, err_zero, err_timeout, err_range;
  logic [SIZE-1:0] calc_n_ref, calc_n_echo, temp_avg;
  logic [2:0]      state_dbg;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  temp_meas_ctrl #(.SIZE(SIZE), .AVG_LOG(AVG_LOG), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .meas_req(meas_req), .cnt_valid(cnt_valid),
    .n_ref_in(n_ref_in), .n_echo_in(n_echo_in), .calc_strt(calc_strt),
    .calc_n_ref(calc_n_ref), .calc_n_echo(calc_n_echo), .calc_temp(calc_temp),
    .calc_rdy(calc_rdy), .temp_avg(temp_avg), .avg_valid(avg_valid), .busy(busy),
    .err_zero(err_zero), .err_timeout(err_timeout), .err_range(err_range),
    .err_clr(err_clr), .state_dbg(state_dbg)
  );

  // scoreboard / reference state
  int              n_cmp = 0;
  int              n_bad = 0;
  logic [SIZE-1:0] exp_q[$];
  logic [SIZE-1:0] fixed_temps[$];
  bit              fixed_ops;
  logic [SIZE-1:0] fix_ref, fix_echo;
  logic [SIZE-1:0] last_avg;
  bit              exp_zero, exp_to, exp_rng;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_flags();
    check("err_zero", err_zero, exp_zero);
    check("err_timeout", err_timeout, exp_to);
    check("err_range", err_range, exp_rng);
  endtask

  task automatic check_reset_outputs();
    check("rst_calc_strt", calc_strt, 0);
    check("rst_calc_n_ref", calc_n_ref, 0);
    check("rst_calc_n_echo", calc_n_echo, 0);
    check("rst_temp_avg", temp_avg, 0);
    check("rst_avg_valid", avg_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_state", state_dbg, 0);
    last_avg = '0;
    exp_zero = 0; exp_to = 0; exp_rng = 0;
    check_flags();
  endtask

  task automatic clear_errs();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    exp_zero = 0; exp_to = 0; exp_rng = 0;
    check_flags();
  endtask

  // Every avg_valid pulse must match the oldest predicted average.
  always @(negedge clk) begin
    if (!rst && avg_valid) begin
      if (exp_q.size() == 0) check("avg_unexpected", avg_valid, 0);
      else                   check("temp_avg", temp_avg, exp_q.pop_front());
    end
  end

  // driver tasks
  task automatic send_pair(input logic [SIZE-1:0] r, input logic [SIZE-1:0] e,
                           input bit rdy_noise, input bit req_noise);
    cnt_valid = 1'b1;
    n_ref_in  = r;
    n_echo_in = e;
    if (rdy_noise) begin
      calc_rdy  = 1'b1;
      calc_temp = '1;
    end
    if (req_noise) meas_req = 1'b1;
    tick();
    cnt_valid = 1'b0;
    calc_rdy  = 1'b0;
    meas_req  = 1'b0;
    n_ref_in  = $urandom;
    n_echo_in = $urandom;
  endtask

  // abort_kind: 0 complete, 1 timeout, 2 negative result, 3 reset in WAIT_CALC
  task automatic do_burst(input int abort_kind, input int abort_at,
                          input bit zero_first, input bit noise);
    longint          sum;
    logic [SIZE-1:0] r, e, t;
    int              d;
    sum = 0;
    meas_req = 1'b1;
    tick();
    meas_req = 1'b0;
    check("busy_after_req", busy, 1);
    for (int s = 0; s < NS; s++) begin
      if (zero_first && s == 0) begin
        send_pair($urandom, '0, 1'b0, 1'b0);
        exp_zero = 1;
        check("strt_on_zero", calc_strt, 0);
        check("busy_on_zero", busy, 1);
        check_flags();
      end
      r = fixed_ops ? fix_ref  : $urandom;
      e = fixed_ops ? fix_echo : SIZE'($urandom_range(65535, 1));
      send_pair(r, e, noise && ($urandom_range(1, 0) == 1), noise && s == 1);
      check("calc_strt_k1", calc_strt, 1);
      check("calc_n_ref", calc_n_ref, r);
      check("calc_n_echo", calc_n_echo, e);
      tick();
      check("calc_strt_drop", calc_strt, 0);
      if (abort_kind == 1 && s == abort_at) begin
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        check("busy_pre_timeout", busy, 1);
        check("err_timeout_pre", err_timeout, exp_to);
        check("n_ref_hold_to", calc_n_ref, r);
        tick();
        exp_to = 1;
        check("busy_post_timeout", busy, 0);
        check("avg_hold_timeout", temp_avg, last_avg);
        check_flags();
        return;
      end
      if (abort_kind == 3 && s == abort_at) begin
        tick();
        tick();
        rst = 1'b1;
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      d = $urandom_range(6, 0);
      for (int i = 0; i < d; i++) begin
        tick();
        check("n_ref_hold", calc_n_ref, r);
        check("n_echo_hold", calc_n_echo, e);
      end
      if (fixed_temps.size() > 0) t = fixed_temps.pop_front();
      else if ($urandom_range(3, 0) == 0) t = 32'h7FFF_FFFF;
      else t = $urandom & 32'h7FFF_FFFF;
      if (abort_kind == 2 && s == abort_at) t = 32'h8000_1000;
      calc_rdy  = 1'b1;
      calc_temp = t;
      check("n_ref_at_rdy", calc_n_ref, r);
      check("n_echo_at_rdy", calc_n_echo, e);
      tick();
      calc_rdy  = 1'b0;
      calc_temp = $urandom;
      if (t[SIZE-1]) begin
        exp_rng = 1;
        check("busy_post_range", busy, 0);
        check("avg_hold_range", temp_avg, last_avg);
        check_flags();
        return;
      end
      sum += longint'(t);
      if (s == NS - 1) begin
        last_avg = SIZE'(sum / NS);
        exp_q.push_back(last_avg);
      end
      tick();
      if (s == NS - 1) begin
        check("avg_valid_pulse", avg_valid, 1);
        tick();
        check("busy_after_done", busy, 0);
        check("avg_valid_one_cycle", avg_valid, 0);
        check("avg_held", temp_avg, last_avg);
      end else begin
        check("busy_mid_burst", busy, 1);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; meas_req = 0; cnt_valid = 0; calc_rdy = 0; err_clr = 0;
    n_ref_in = '0; n_echo_in = '0; calc_temp = '0;
    fixed_ops = 0; fix_ref = '0; fix_echo = '0;
    repeat (3) tick();
    check_reset_outputs();
    rst = 1'b0;

    // directed average with fixed operands; request on the first edge after reset
    fixed_ops = 1; fix_ref = 1000; fix_echo = 900;
    fixed_temps = '{32'd819200, 32'd819200, 32'd852000, 32'd852000};
    do_burst(0, 0, 1'b0, 1'b0);
    check("avg_directed", temp_avg, 835600);

    // zero echo first, then echo 500 proceeds; clear afterwards
    fix_ref = 1234; fix_echo = 500;
    do_burst(0, 0, 1'b1, 1'b0);
    clear_errs();
    fixed_ops = 0;

    do_burst(1, 2, 1'b0, 1'b0);
    clear_errs();
    do_burst(2, 1, 1'b0, 1'b0);
    clear_errs();

    // reset in WAIT_CALC after two samples, then a fresh burst with busy requests
    do_burst(3, 2, 1'b0, 1'b1);
    do_burst(0, 0, 1'b0, 1'b1);

    for (int n = 0; n < 10; n++) begin
      int r, kind;
      r = $urandom_range(9, 0);
      kind = (r < 6) ? 0 : (r < 7) ? 1 : (r < 9) ? 2 : 3;
      do_burst(kind, $urandom_range(NS - 1, 0), $urandom_range(1, 0) == 1, 1'b1);
      if ($urandom_range(1, 0) == 1) clear_errs();
    end

    // clear wins over a zero-echo error in the same cycle
    clear_errs();
    meas_req = 1'b1;
    tick();
    meas_req = 1'b0;
    err_clr = 1'b1;
    send_pair(32'd5, '0, 1'b0, 1'b0);
    err_clr = 1'b0;
    check("strt_on_zero_clr", calc_strt, 0);
    check_flags();
    rst = 1'b1;
    #1;
    check_reset_outputs();
    tick();
    rst = 1'b0;
    tick();

    check("exp_q_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
